// File: rtl/vga_pkg.sv
// Shared VGA types and constants: 640x480@60 timing defaults, colour-bar table
// and the sync/blank control word carried through the output delay line.
package vga_pkg;

    localparam int COLOR_W_DEF  = 8;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // {R,G,B} on/off per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] COLOR_BARS = {
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_ctl_t;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return COLOR_BARS[idx];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a configurable reset word; DEPTH=0 is a
// straight wire so callers can use it for any source latency.
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic clk_rst_unused;
            assign clk_rst_unused = clk ^ rst_n;
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

            always_comb begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= {DEPTH{RST_VAL}};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing generator with zero-latency pixel requests and a DAC output stage
// aligned to the source read latency. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int   COLOR_W  = COLOR_W_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter int   DATA_LAT = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW       = $clog2(H_TOTAL),
    localparam int  YW       = $clog2(V_TOTAL)
) (
    input  logic               iPIXEL_CLK,
    input  logic               iRST_N,
    input  logic               iEN,
    input  logic [COLOR_W-1:0] iDATA_R,
    input  logic [COLOR_W-1:0] iDATA_G,
    input  logic [COLOR_W-1:0] iDATA_B,
    input  logic               iTEST_MODE,
    output logic               oREQ,
    output logic [XW-1:0]      oX,
    output logic [YW-1:0]      oY,
    output logic               oFRAME_START,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK_N,
    output logic               oVGA_SYNC_N
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam vga_ctl_t CTL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap, v_wrap, active, req;
    vga_ctl_t      ctl_raw, ctl_dly;

    always_comb begin
        h_wrap  = (int'(h_cnt_q) == H_TOTAL - 1);
        v_wrap  = (int'(v_cnt_q) == V_TOTAL - 1);
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (!iEN) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iPIXEL_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Request side is gated by reset too, so the source sees no request while held.
    assign active       = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    assign req          = iRST_N && iEN && active;
    assign oREQ         = req;
    assign oX           = req ? h_cnt_q : '0;
    assign oY           = req ? v_cnt_q : '0;
    assign oFRAME_START = iRST_N && iEN && (h_cnt_q == '0) && (v_cnt_q == '0);

    // The counters still hold their running value on the first disabled cycle.
    always_comb begin
        ctl_raw.hs = (iEN && (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END))
                     ? HS_POL : ~HS_POL;
        ctl_raw.vs = (iEN && (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END))
                     ? VS_POL : ~VS_POL;
        ctl_raw.blank_n = req;
    end

    vga_delay_line #(
        .DEPTH   (DATA_LAT),
        .WIDTH   ($bits(vga_ctl_t)),
        .RST_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .clk   (iPIXEL_CLK),
        .rst_n (iRST_N),
        .d     (ctl_raw),
        .q     (ctl_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_raw, bar_dly, bar_on;

    assign bar_raw = 3'(h_cnt_q / XW'(BAR_W));

    vga_delay_line #(
        .DEPTH   (DATA_LAT),
        .WIDTH   (3),
        .RST_VAL (3'd0)
    ) u_bar_dly (
        .clk   (iPIXEL_CLK),
        .rst_n (iRST_N),
        .d     (bar_raw),
        .q     (bar_dly)
    );

    assign bar_on = bar_rgb(bar_dly);
`else
    logic test_mode_unused;
    assign test_mode_unused = iTEST_MODE;
`endif

    logic [COLOR_W-1:0] src_r, src_g, src_b;
    logic [COLOR_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
    logic               hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

    always_comb begin
        src_r = iDATA_R;
        src_g = iDATA_G;
        src_b = iDATA_B;
`ifdef VGA_TEST_PATTERN_EN
        if (iTEST_MODE) begin
            src_r = {COLOR_W{bar_on[2]}};
            src_g = {COLOR_W{bar_on[1]}};
            src_b = {COLOR_W{bar_on[0]}};
        end
`endif
        vga_r_d   = ctl_dly.blank_n ? src_r : '0;
        vga_g_d   = ctl_dly.blank_n ? src_g : '0;
        vga_b_d   = ctl_dly.blank_n ? src_b : '0;
        hs_d      = ctl_dly.hs;
        vs_d      = ctl_dly.vs;
        blank_n_d = ctl_dly.blank_n;
    end

    always_ff @(posedge iPIXEL_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vga_r_q   <= '0;
            vga_g_q   <= '0;
            vga_b_q   <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
        end else begin
            vga_r_q   <= vga_r_d;
            vga_g_q   <= vga_g_d;
            vga_b_q   <= vga_b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign oVGA_R       = vga_r_q;
    assign oVGA_G       = vga_g_q;
    assign oVGA_B       = vga_b_q;
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_BLANK_N = blank_n_q;
    assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Parametrised VGA timing generator plus aligned output stage.
- Generates HS/VS/BLANK from internal counters and issues pixel requests (oREQ, oX, oY) to the pixel source.
- Delays sync/blank to match the source's fixed read latency, then registers RGB to the DAC pins.
- Sits between the frame-buffer/pixel source and the board VGA DAC; it is the sole driver of the oVGA_* pins.

Parameters:
- COLOR_W, 8, bits per colour channel.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, HS pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, VS pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- DATA_LAT, 2, cycles from request (oREQ/oX/oY) to valid iDATA_*; range 0..15.
- HS_POL, 0, active level of oVGA_HS.
- VS_POL, 0, active level of oVGA_VS.

Ports:
- iPIXEL_CLK in 1: pixel clock.
- iRST_N in 1: asynchronous active-low reset.
- iEN in 1: timing run enable.
- iDATA_R in COLOR_W: red from pixel source.
- iDATA_G in COLOR_W: green from pixel source.
- iDATA_B in COLOR_W: blue from pixel source.
- iTEST_MODE in 1: select test pattern (TEST_PATTERN_EN builds only).
- oREQ out 1: pixel request; high while counters are in the active region.
- oX out XW: active column, where XW = clog2(H_TOTAL).
- oY out YW: active row, where YW = clog2(V_TOTAL).
- oFRAME_START out 1: one-cycle pulse at counter (0,0).
- oVGA_R out COLOR_W: red to DAC.
- oVGA_G out COLOR_W: green to DAC.
- oVGA_B out COLOR_W: blue to DAC.
- oVGA_HS out 1: horizontal sync.
- oVGA_VS out 1: vertical sync.
- oVGA_BLANK_N out 1: low during blanking.
- oVGA_SYNC_N out 1: constant 0 (no sync-on-green).

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Line region order: active, FP, SYNC, BP.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and wraps V_TOTAL-1 -> 0 on an h wrap.
- Request side is combinational from the counters, with zero latency:
  - oREQ = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - oX = h_cnt and oY = v_cnt while oREQ, else 0.
  - oFRAME_START = (h_cnt == 0 && v_cnt == 0 && iEN).
- Raw sync/blank are derived from the counters, delayed through a (DATA_LAT+1)-stage delay line, and appear at the pins together with the RGB registered from iDATA_*.
- Latency: a request at cycle t appears on oVGA_* at cycle t+DATA_LAT+1.
- Output RGB is forced to 0 whenever the delayed blank is active, regardless of iDATA.
- Reset (async, iRST_N=0):
  - Counters = 0; all delay stages hold inactive values.
  - oVGA_R/G/B = 0, oVGA_HS = ~HS_POL, oVGA_VS = ~VS_POL, oVGA_BLANK_N = 0, oVGA_SYNC_N = 0.
  - oREQ = 0, oFRAME_START = 0.
  - First cycle after release with iEN=1: oREQ=1 at (0,0).
- iEN=0:
  - Counters are held at 0 and oREQ is forced to 0.
  - The delay line keeps shifting inactive values, so the pins reach the idle state after DATA_LAT+1 cycles.
  - iEN re-asserted: timing restarts at (0,0) on that cycle.
- Reset mid-frame: all state clears immediately with no partial line; restart at (0,0).
- Simultaneous h wrap and v wrap: both counters go to 0 in the same cycle, and oFRAME_START pulses in the next cycle.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined, with iTEST_MODE=1: iDATA_* are ignored. The RGB stage shows 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in this order: white, yellow, cyan, green, magenta, red, blue, black. Channel values are all-ones or 0.
- The pattern uses the delayed column so it stays aligned with the sync/blank latency.
- Undefined: iTEST_MODE exists but is ignored, and there is no pattern logic.

Decomposition:
- Package vga_pkg:
  - COLOR_W default.
  - 640x480@60 timing constants.
  - Colour-bar constant array.
  - Struct vga_ctl_t {hs, vs, blank_n} used in the delay line.
- Sub-module vga_delay_line: parametrised depth/width shift register with a reset-value parameter; used for the control signals and for the pattern column.

Test Plan:
- Reset: hold iRST_N=0 with iEN=1 and iDATA=FF -> all outputs at their reset values. Release -> oREQ=1, oX=0, oY=0 on the first edge.
- Horizontal timing, defaults, DATA_LAT=2 -> oVGA_HS low for exactly 96 cycles with period 800. First HS fall occurs 656+3 cycles after the first oREQ.
- Vertical timing -> oVGA_VS low for exactly 1600 cycles. oFRAME_START period is 420000 cycles.
- Latency and blanking: source model returns iDATA_R = oX[7:0] after 2 cycles -> oVGA_R equals 0,1,2,... starting 3 cycles after the line starts, and is 0 through blanking even with iDATA forced to FF.
- Mid-frame disruption:
  - iRST_N pulsed at h=300, v=100 -> outputs reset immediately; restart at (0,0).
  - iEN dropped -> BLANK_N=0 within 3 cycles.
- VGA_TEST_PATTERN_EN build, iTEST_MODE=1 -> at column 0 RGB = (FF,FF,FF); at column 80 RGB = (FF,FF,00); at column 560 RGB = (00,00,00).
